// File: rtl/polar_enc_seq.sv
// Sequential polar encoder: x = u * F^(kron LOG_N), one butterfly stage per clock.
// Define POLAR_ENC_BIT_REVERSE_EN to emit the codeword in bit-reversed index order.
//
// state | meaning
// IDLE  | ready for a frame; in_ready high
// ENC   | applying butterfly stage cnt_q to the working register
// OUT   | codeword valid, held until out_ready
module polar_enc_seq #(
    parameter int N = 16,
    parameter int LOG_N = 4,
    parameter int K = 8,
    parameter logic [N-1:0] INFO_MASK = 16'hFE80
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [K-1:0] info_bits,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] code_bits,
    output logic         busy
);

    localparam int CW = $clog2(LOG_N) + 1;

    typedef enum logic [1:0] {
        IDLE,
        ENC,
        OUT
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    x_q, x_d;
    logic [N-1:0]    u_load;
    logic [N-1:0]    x_enc;

    logic [LOG_N-1:0][N-1:0] stage_x;
    logic [LOG_N:0][N-1:0]   stage_sel;

    // Number of info positions below pos: which info_bits entry lands at u_pos.
    function automatic int info_rank(input int pos);
        int r;
        r = 0;
        for (int b = 0; b < pos; b++) begin
            if (INFO_MASK[b]) r++;
        end
        return r;
    endfunction

`ifdef POLAR_ENC_BIT_REVERSE_EN
    function automatic int bitrev(input int v);
        int r;
        r = 0;
        for (int b = 0; b < LOG_N; b++) begin
            if (((v >> b) & 1) == 1) r = r | (1 << (LOG_N - 1 - b));
        end
        return r;
    endfunction
`endif

    for (genvar i = 0; i < N; i++) begin : g_load
        if (INFO_MASK[i] && (info_rank(i) < K)) begin : g_info
            assign u_load[i] = info_bits[info_rank(i)];
        end else begin : g_frozen
            assign u_load[i] = 1'b0;
        end
    end

    // Every stage is built in parallel; cnt_q selects the one applied this cycle.
    for (genvar s = 0; s < LOG_N; s++) begin : g_stage
        for (genvar i = 0; i < N; i++) begin : g_bit
            if (((i >> s) & 1) == 0) begin : g_xor
                assign stage_x[s][i] = x_q[i] ^ x_q[i + (1 << s)];
            end else begin : g_pass
                assign stage_x[s][i] = x_q[i];
            end
        end
        assign stage_sel[s+1] = (cnt_q == CW'(s)) ? stage_x[s] : stage_sel[s];
    end

    assign stage_sel[0] = x_q;
    assign x_enc        = stage_sel[LOG_N];

    for (genvar i = 0; i < N; i++) begin : g_out
`ifdef POLAR_ENC_BIT_REVERSE_EN
        assign code_bits[N-1-i] = x_q[bitrev(i)];
`else
        assign code_bits[N-1-i] = x_q[i];
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = u_load;
                    cnt_d   = '0;
                    state_d = ENC;
                end
            end
            ENC: begin
                x_d = x_enc;
                if (cnt_q == CW'(LOG_N - 1)) begin
                    cnt_d   = '0;
                    state_d = OUT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            OUT: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/polar_enc_seq.md
POLAR_ENC_SEQ -- requirements
Module: polar_enc_seq

Interface
REQ-001 Parameter N, default 16, SHALL be the codeword length (power of two, 8..64).
REQ-002 Parameter LOG_N, default 4, SHALL equal log2(N).
REQ-003 Parameter K, default 8, SHALL be the number of info bits (1..N).
REQ-004 Parameter INFO_MASK, default 16'hFE80, SHALL mark info positions: bit i set means u_i carries info, clear means frozen; popcount SHALL equal K.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 in_valid  input  1  info_bits valid.
REQ-008 in_ready  output  1  encoder can accept a frame.
REQ-009 info_bits  input  K  info bits; info_bits[0] maps to the lowest-index set INFO_MASK position, ascending.
REQ-010 out_valid  output  1  code_bits valid.
REQ-011 out_ready  input  1  downstream accepts code_bits.
REQ-012 code_bits  output  N  codeword; x_0 at MSB (code_bits[N-1-i] = x_i), same packing as the decoder LLR bus.
REQ-013 busy  output  1  high in any state except IDLE.

Function
REQ-014 FSM states SHALL be IDLE, ENC, OUT.
REQ-015 IDLE: in_ready=1; on in_valid&in_ready, load u (frozen positions=0, info per REQ-009) into working register x; stage counter=0; go to ENC.
REQ-016 ENC: each cycle applies stage s=counter: for every i with bit s of i equal 0, x_i <= x_i XOR x_(i+2^s); counter increments.
REQ-017 After stage LOG_N-1, FSM SHALL go to OUT; result SHALL equal x = u·F^⊗LOG_N, F=[[1,0],[1,1]] (x_j = XOR of u_i over all i whose bits include j's bits).
REQ-018 Latency: out_valid SHALL rise LOG_N+1 cycles after the accepting cycle (5 for N=16).
REQ-019 OUT: out_valid=1; code_bits and out_valid SHALL hold stable while out_ready=0; on out_ready=1 go to IDLE.
REQ-020 in_ready SHALL be 0 in ENC and OUT; in_valid there is ignored, no frame is lost or overwritten.
REQ-021 Throughput: one frame per LOG_N+2 cycles minimum; out_ready tied high SHALL sustain it.
REQ-022 code_bits SHALL be driven only from registers; no combinational path from in_* to out_*.
REQ-023 Stage counter width SHALL be ceil(log2(LOG_N))+1; no wrap inside ENC.

Reset
REQ-024 rst_n=0 at a clock edge SHALL force IDLE, counter=0, x=0, out_valid=0, busy=0, in_ready=1 next cycle.
REQ-025 Reset in ENC or OUT SHALL abort the frame; no out_valid for it ever appears.
REQ-026 in_valid during the reset cycle SHALL NOT be accepted.

Configuration
REQ-027 Macro POLAR_ENC_BIT_REVERSE_EN, defined: code_bits[N-1-i] = x_(bitrev_LOG_N(i)) (bit-reversed output order); undefined: natural order per REQ-012; latency identical in both builds.

Verification (N=16, K=8, INFO_MASK=16'hFE80)
REQ-028 info_bits=8'h00 accepted -> out_valid after 5 cycles, code_bits=16'h0000.
REQ-029 info_bits=8'h01 (u_7=1) -> code_bits=16'hFF00; with POLAR_ENC_BIT_REVERSE_EN -> 16'hAAAA.
REQ-030 info_bits=8'h02 (u_9=1) -> 16'hC0C0; info_bits=8'h80 (u_15=1) -> 16'hFFFF.
REQ-031 Backpressure: out_ready=0 for 3 cycles in OUT with in_valid=1 -> out_valid, code_bits stable, in_ready=0; out_ready=1 -> IDLE next cycle, then next frame accepted.
REQ-032 rst_n=0 during stage 2 -> in_ready=1, out_valid=0 next cycle; next frame 8'h01 yields 16'hFF00 with latency 5.
REQ-033 Back-to-back 100 random frames, out_ready=1 -> each output matches golden u·F^⊗4 model, one frame per 6 cycles.
